// File: rtl/hilo_div.sv
// hilo_div: iterative 32/32 divider that writes HI (remainder) and LO (quotient).
// One radix-2 restoring step per cycle; signed operands are handled by dividing
// magnitudes and fixing the signs of the final quotient and remainder.
// Optional build macro: HILO_DIV_ZERO_FAST_EN -- when defined, a zero divisor
// skips the iteration and completes on the cycle after start.
module hilo_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        stallreq,
    output logic        hi_we,
    output logic [31:0] hi_data,
    output logic        lo_we,
    output logic [31:0] lo_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;      // partial remainder
    logic [31:0] r_quo;      // dividend bits shifting out, quotient bits shifting in
    logic [31:0] r_dvs;      // divisor magnitude
    logic        r_neg_q;    // quotient must be negated at the end
    logic        r_neg_r;    // remainder must be negated at the end
    logic        r_dvz;      // divisor was zero
    logic        r_armed;    // low for the first cycle after reset
    logic        r_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_lo_fin;
    logic [31:0] w_hi_fin;

    // Magnitude of a two's complement value when signed mode is selected.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        logic signed [31:0] s;
        s = $signed(v);
        if (en && (s < 0))
            return $unsigned(-s);
        return v;
    endfunction

    // Two's complement negation when requested.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        logic signed [31:0] s;
        s = $signed(v);
        if (en)
            return $unsigned(-s);
        return v;
    endfunction

    // One restoring step plus the sign-corrected result of the final step.
    always_comb begin
        w_trial   = {r_rem, r_quo[31]};
        w_diff    = w_trial - {1'b0, r_dvs};
        w_qbit    = ~w_diff[32];
        w_rem_nxt = w_qbit ? w_diff[31:0] : w_trial[31:0];
        w_quo_nxt = {r_quo[30:0], w_qbit};
        w_lo_fin  = r_dvz ? 32'hFFFF_FFFF : neg_if(w_quo_nxt, r_neg_q);
        w_hi_fin  = neg_if(w_rem_nxt, r_neg_r);
    end

    // Stall while a request is being accepted and for the whole iteration.
    always_comb begin
        stallreq = resetn && (((r_state == S_IDLE) && r_armed && start && !annul)
                              || (r_state == S_DIV));
    end

    // Strobes are suppressed immediately by a flush or reset in the DONE cycle.
    always_comb begin
        hi_we   = r_we && resetn && !annul;
        lo_we   = r_we && resetn && !annul;
        hi_data = resetn ? r_hi : 32'd0;
        lo_data = resetn ? r_lo : 32'd0;
    end

    // Control FSM and iteration datapath with registered results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_armed <= 1'b0;
            r_we    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_armed <= 1'b1;
            r_we    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            if (annul) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && r_armed) begin
                            r_cnt   <= 5'd0;
                            r_rem   <= 32'd0;
                            r_quo   <= abs_if(dividend, signed_div);
                            r_dvs   <= abs_if(divisor, signed_div);
                            r_neg_q <= signed_div & (dividend[31] ^ divisor[31]);
                            r_neg_r <= signed_div & dividend[31];
                            r_dvz   <= (divisor == 32'd0);
`ifdef HILO_DIV_ZERO_FAST_EN
                            if (divisor == 32'd0) begin
                                r_state <= S_DONE;
                                r_we    <= 1'b1;
                                r_lo    <= 32'hFFFF_FFFF;
                                r_hi    <= dividend;
                            end else begin
                                r_state <= S_DIV;
                            end
`else
                            r_state <= S_DIV;
`endif
                        end
                    end
                    S_DIV: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= S_DONE;
                            r_we    <= 1'b1;
                            r_lo    <= w_lo_fin;
                            r_hi    <= w_hi_fin;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: scoreboard bench for hilo_div. Expected results and strobe
// cycles are queued when an operation is launched and checked when the
// HI/LO strobe appears.
module tb_hilo_div;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq;
    logic        hi_we;
    logic [31:0] hi_data;
    logic        lo_we;
    logic [31:0] lo_data;

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    hilo_div dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stallreq   (stallreq),
        .hi_we      (hi_we),
        .hi_data    (hi_data),
        .lo_we      (lo_we),
        .lo_data    (lo_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_tests = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sd) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
        end else begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
        end
    endfunction

    // Output monitor: strobes are matched against the scoreboard, otherwise data must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stallreq) stall_cnt++;
            if (hi_we || lo_we) begin
                if (sb.size() == 0) begin
                    check("stray_strobe", 32'd1, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check("lo_data", lo_data, e_mon.lo);
                    check("hi_data", hi_data, e_mon.hi);
                    check("strobe_cycle", 32'(cyc), 32'(e_mon.at));
                    check("we_pair", {30'd0, hi_we, lo_we}, 32'd3);
                    check("stall_done", {31'd0, stallreq}, 32'd0);
                end
            end else begin
                check("hi_idle", hi_data, 32'd0);
                check("lo_idle", lo_data, 32'd0);
            end
        end
    end

    // Launch one operation (called just after a rising edge) and wait for its strobe.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, input int lat);
        exp_t e;
        int   n;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        e.lo = lo;
        e.hi = hi;
        e.at = cyc + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, elo, ehi;
        logic        rsd;

        resetn     = 1'b0;
        start      = 1'b1;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        check("rst_we", {30'd0, hi_we, lo_we}, 32'd0);

        // First cycle out of reset: start held high must not stall or launch.
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic unsigned divide with latency and stall length.
        stall_cnt = 0;
        do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        check("stall_len", 32'(stall_cnt), 32'd33);

        // Signed cases and boundaries, issued back to back.
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);

        // Divide by zero in both modes.
        do_div(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, ZLAT);
        do_div(1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, ZLAT);
        do_div(1'b1, 32'hFFFF_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_0000, ZLAT);

        // Start together with annul in IDLE is dropped.
        signed_div = 1'b0;
        dividend   = 32'd50;
        divisor    = 32'd5;
        start      = 1'b1;
        annul      = 1'b1;
        @(negedge clk);
        check("annul_start_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        check("annul_start_idle", {31'd0, stallreq}, 32'd0);

        // Annul at DIV cycle 10: no strobe, back in IDLE next cycle.
        @(posedge clk); #1;
        dividend = 32'h0000_FFFF;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check("div_stall", {31'd0, stallreq}, 32'd1);
        @(posedge clk); #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul_idle", {31'd0, stallreq}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Reset at DIV cycle 20, then back-to-back operations.
        dividend = 32'h1234_5678;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        check("rst_div_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_div_idle", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        do_div(1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 33);
        do_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33);

        // Random operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            rsd = 1'($urandom_range(0, 1));
            model(rsd, ra, rb, elo, ehi);
            do_div(rsd, ra, rb, elo, ehi, (rb == 32'd0) ? ZLAT : 33);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
